// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator, shifts a latched pattern out MSB-first
// with programmable repeat count and idle gap between repetitions.
module seq_gen #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(PAT_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] sr, sr_n, pat_q, pat_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [CNT_W-1:0] rep_left, rep_n, gap_q, gap_q_n, gap_left, gap_left_n;
    logic             x_n, valid_n, busy_n, done_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= '0;
            pat_q    <= '0;
            bit_cnt  <= '0;
            rep_left <= '0;
            gap_q    <= '0;
            gap_left <= '0;
            x        <= IDLE_BIT;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            pat_q    <= pat_n;
            bit_cnt  <= bit_n;
            rep_left <= rep_n;
            gap_q    <= gap_q_n;
            gap_left <= gap_left_n;
            x        <= x_n;
            valid    <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so that x/valid/busy/done stay registered.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        pat_n      = pat_q;
        bit_n      = bit_cnt;
        rep_n      = rep_left;
        gap_q_n    = gap_q;
        gap_left_n = gap_left;
        x_n        = x;
        valid_n    = valid;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEND;
                    pat_n   = pattern;
                    sr_n    = pattern;
                    rep_n   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    gap_q_n = gap;
                    bit_n   = '0;
                    x_n     = pattern[PAT_W-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SEND: begin
                if (bit_cnt != BW'(PAT_W - 1)) begin
                    sr_n  = sr << 1;
                    x_n   = sr[PAT_W-2];
                    bit_n = bit_cnt + 1'b1;
                end else if (rep_left > CNT_W'(1)) begin
                    rep_n = rep_left - 1'b1;
                    if (gap_q != '0) begin
                        state_n    = GAP;
                        gap_left_n = gap_q;
                        x_n        = IDLE_BIT;
                        valid_n    = 1'b0;
                    end else begin
                        sr_n  = pat_q;
                        x_n   = pat_q[PAT_W-1];
                        bit_n = '0;
                    end
                end else begin
                    state_n = DONE;
                    x_n     = IDLE_BIT;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            GAP: begin
                if (gap_left == CNT_W'(1)) begin
                    state_n = SEND;
                    sr_n    = pat_q;
                    x_n     = pat_q[PAT_W-1];
                    valid_n = 1'b1;
                    bit_n   = '0;
                end else begin
                    gap_left_n = gap_left - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed-vector bench for seq_gen; outputs sampled on the falling edge
// and compared as {x, valid, busy, done}.
module tb_seq_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic [7:0] gap;
    logic       x, valid, busy, done;
    int         vectors = 0;
    int         miscompares = 0;

    seq_gen #(.PAT_W(4), .CNT_W(8), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .gap(gap),
        .x(x), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [3:0] expv, input string tag);
        logic [3:0] got;
        got = {x, valid, busy, done};
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: {x,valid,busy,done} got %b expected %b", tag, got, expv);
        end
    endtask

    task automatic step(input logic [3:0] expv, input string tag);
        @(negedge clk);
        chk(expv, tag);
    endtask

    // Pattern bits MSB-first, each with valid=1 busy=1 done=0.
    task automatic bits(input logic [15:0] b, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step({b[i], 3'b110}, tag);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
        @(negedge clk);
        chk(4'b1000, "reset");
        reset = 1'b1;
        step(4'b1000, "idle_after_reset");

        // 1: single 0110
        pattern = 4'b0110; repeat_cnt = 8'd1; gap = 8'd0; start = 1'b1;
        step(4'b0110, "t1_b0");
        start = 1'b0;
        bits(16'b110, 3, "t1_bits");
        step(4'b1001, "t1_done");
        step(4'b1000, "t1_idle");

        // 2: 1010 x3, gap 2
        pattern = 4'b1010; repeat_cnt = 8'd3; gap = 8'd2; start = 1'b1;
        step(4'b1110, "t2_b0");
        start = 1'b0;
        bits(16'b010, 3, "t2_rep1");
        step(4'b1010, "t2_gap1a");
        step(4'b1010, "t2_gap1b");
        bits(16'b1010, 4, "t2_rep2");
        step(4'b1010, "t2_gap2a");
        step(4'b1010, "t2_gap2b");
        bits(16'b1010, 4, "t2_rep3");
        step(4'b1001, "t2_done");
        step(4'b1000, "t2_idle");

        // 3: repeat_cnt 0 acts as 1
        pattern = 4'b0011; repeat_cnt = 8'd0; gap = 8'd3; start = 1'b1;
        step(4'b0110, "t3_b0");
        start = 1'b0;
        bits(16'b011, 3, "t3_bits");
        step(4'b1001, "t3_done");
        step(4'b1000, "t3_idle");

        // 4: back-to-back 0110 x2
        pattern = 4'b0110; repeat_cnt = 8'd2; gap = 8'd0; start = 1'b1;
        step(4'b0110, "t4_b0");
        start = 1'b0;
        bits(16'b1100110, 7, "t4_bits");
        step(4'b1001, "t4_done");
        step(4'b1000, "t4_idle");

        // 5: start held, inputs changed while busy
        pattern = 4'b0110; repeat_cnt = 8'd1; gap = 8'd0; start = 1'b1;
        step(4'b0110, "t5_b0");
        pattern = 4'b1111; repeat_cnt = 8'd3; gap = 8'd4;
        bits(16'b110, 3, "t5_bits");
        repeat_cnt = 8'd1; gap = 8'd0;
        step(4'b1001, "t5_done");
        step(4'b1000, "t5_idle_start_in_done_ignored");
        step(4'b1110, "t5_restart_b0");
        start = 1'b0;
        bits(16'b111, 3, "t5_restart_bits");
        step(4'b1001, "t5_restart_done");
        step(4'b1000, "t5_restart_idle");

        // 6: async reset during the second bit
        pattern = 4'b0110; repeat_cnt = 8'd2; gap = 8'd1; start = 1'b1;
        step(4'b0110, "t6_b0");
        start = 1'b0;
        step(4'b1110, "t6_b1");
        #2 reset = 1'b0;
        #1 chk(4'b1000, "t6_async_reset");
        step(4'b1000, "t6_in_reset");
        reset = 1'b1;
        step(4'b1000, "t6_no_done");
        step(4'b1000, "t6_idle");
        repeat_cnt = 8'd1; start = 1'b1;
        step(4'b0110, "t6_after_b0");
        start = 1'b0;
        bits(16'b110, 3, "t6_after_bits");
        step(4'b1001, "t6_after_done");
        step(4'b1000, "t6_after_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
